// File: rtl/board_shuffler.sv
// Board shuffler: loads the canonical 32-square layout, optionally Fisher-Yates shuffles it
// with a 16-bit Galois LFSR, then streams it out one square per cycle. Define SHUFFLE_EN for the shuffle.
module board_shuffler (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [15:0] seed,
    output logic [4:0]  board_out_addr,
    output logic [4:0]  board_out_piece,
    output logic        board_change_en,
    output logic        busy,
    output logic        done
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD   | canonical layout written, LFSR seeded, i=31
    // DRAW   | LFSR steps; candidate j accepted when j<=i
    // SWAP   | arr[i] <-> arr[j], then i-- or move to EMIT
    // EMIT   | one square per cycle, k = 0..31
    // DONE   | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_SWAP,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [2:0] T_P = 3'b001;
    localparam logic [2:0] T_C = 3'b010;
    localparam logic [2:0] T_N = 3'b011;
    localparam logic [2:0] T_R = 3'b100;
    localparam logic [2:0] T_B = 3'b101;
    localparam logic [2:0] T_Q = 3'b110;
    localparam logic [2:0] T_K = 3'b111;

    state_t     state_q;
    logic [4:0] k_q;
    logic [4:0] arr_q [32];
    logic [4:0] addr_q;
    logic [4:0] piece_q;
    logic       en_q;
    logic       done_q;

    // Rows 0 and 3 are back ranks, rows 1 and 2 pawn ranks; squares below 16 are black.
    function automatic logic [4:0] canon_piece(input logic [4:0] a);
        logic [2:0] t;
        logic       back;
        back = (a[4] == a[3]);
        t    = T_P;
        if (back) begin
            case (a[2:0])
                3'd0, 3'd7: t = T_R;
                3'd1, 3'd6: t = T_N;
                3'd2, 3'd5: t = T_B;
                3'd3:       t = T_Q;
                default:    t = T_K;
            endcase
        end else begin
            case (a[2:0])
                3'd3, 3'd4: t = T_C;
                3'd5:       t = T_Q;
                default:    t = T_P;
            endcase
        end
        return {~a[4], t, 1'b0};
    endfunction

`ifdef SHUFFLE_EN
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [4:0]  i_q;
    logic [4:0]  j_q;
    logic [4:0]  j_cand;

    function automatic logic [4:0] cover_mask(input logic [4:0] v);
        logic [4:0] m;
        m = v | (v >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        j_cand = lfsr_q[4:0] & cover_mask(i_q);
    end
`else
    logic unused_seed;
    assign unused_seed = ^seed;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            k_q     <= 5'd0;
            addr_q  <= 5'd0;
            piece_q <= 5'd0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHUFFLE_EN
            lfsr_q  <= LFSR_DEFAULT;
            i_q     <= 5'd0;
            j_q     <= 5'd0;
`endif
        end else begin
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= 5'd0;
            piece_q <= 5'd0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int n = 0; n < 32; n++) begin
                        arr_q[n] <= canon_piece(5'(n));
                    end
                    k_q <= 5'd0;
`ifdef SHUFFLE_EN
                    i_q     <= 5'd31;
                    lfsr_q  <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
                    state_q <= S_DRAW;
`else
                    state_q <= S_EMIT;
`endif
                end
`ifdef SHUFFLE_EN
                S_DRAW: begin
                    lfsr_q <= lfsr_d;
                    if (j_cand <= i_q) begin
                        j_q     <= j_cand;
                        state_q <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    arr_q[i_q] <= arr_q[j_q];
                    arr_q[j_q] <= arr_q[i_q];
                    if (i_q == 5'd1) begin
                        k_q     <= 5'd0;
                        state_q <= S_EMIT;
                    end else begin
                        i_q     <= i_q - 5'd1;
                        state_q <= S_DRAW;
                    end
                end
`endif
                S_EMIT: begin
                    en_q    <= 1'b1;
                    addr_q  <= k_q;
                    piece_q <= arr_q[k_q];
                    if (k_q == 5'd31) begin
                        state_q <= S_DONE;
                    end else begin
                        k_q <= k_q + 5'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign board_change_en = en_q;
    assign board_out_addr  = addr_q;
    assign board_out_piece = piece_q;
    assign done            = done_q;
    assign busy            = (state_q != S_IDLE);

endmodule
